// File: rtl/vga_rx_decoder.sv
// VGA receiver: recovers pixel coordinates/data from h_sync/v_sync/RGB565 and locks to nominal timing.
// Latency: pixel outputs are registered 1 sys_clk after the qualifying pix_ce sample.
// Backpressure: none; the stream is paced by pix_ce only and cycles with pix_ce=0 leave state untouched.
module vga_rx_decoder #(
    parameter int SYNC_POL    = 1,
    parameter int H_TOTAL     = 800,
    parameter int H_ACT_START = 144,
    parameter int H_VALID     = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_ACT_START = 35,
    parameter int V_VALID     = 480
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        pix_ce,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic [15:0] rgb,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [15:0] pix_data,
    output logic        frame_start,
    output logic        locked,
    output logic        err,
    output logic [11:0] h_total_meas,
    output logic [10:0] v_total_meas
);

    // Sync level that marks an active pulse.
    localparam logic SYNC_ACT = (SYNC_POL != 0);

    // Timing constants at the widths of the counters they are compared with.
    localparam logic [11:0] H_TOT = 12'(H_TOTAL);
    localparam logic [11:0] H_LO  = 12'(H_ACT_START);
    localparam logic [11:0] H_HI  = 12'(H_ACT_START + H_VALID - 1);
    localparam logic [10:0] V_TOT = 11'(V_TOTAL);
    localparam logic [10:0] V_LO  = 11'(V_ACT_START);
    localparam logic [10:0] V_HI  = 11'(V_ACT_START + V_VALID - 1);
    localparam logic [11:0] H_MAX = 12'hFFF;
    localparam logic [10:0] V_MAX = 11'h7FF;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t      state;
    logic        h_prev;
    logic        v_prev;
    logic [11:0] h_cnt;
    logic [10:0] v_cnt;

    logic        h_lead;
    logic        v_lead;
    logic [11:0] h_inc;
    logic [10:0] v_inc;
    logic [11:0] hpos;
    logic [10:0] vpos;
    logic [11:0] meas_h;
    logic        wd_hit;
    logic        in_window;

    // Position of the current sample: edge detection, saturating counters, watchdog and active-window test.
    always_comb begin
        h_lead = 1'b0;
        v_lead = 1'b0;
        h_inc  = h_cnt;
        v_inc  = v_cnt;
        hpos   = h_cnt;
        vpos   = v_cnt;
        meas_h = h_total_meas;
        wd_hit = 1'b0;
        in_window = 1'b0;

        h_lead = (h_sync == SYNC_ACT) && (h_prev != SYNC_ACT);
        v_lead = (v_sync == SYNC_ACT) && (v_prev != SYNC_ACT);

        // h_inc doubles as the length of the line that an h edge terminates.
        h_inc = (h_cnt == H_MAX) ? H_MAX : h_cnt + 12'd1;
        v_inc = (v_cnt == V_MAX) ? V_MAX : v_cnt + 11'd1;

        hpos = h_lead ? 12'd0 : h_inc;
        if (v_lead) begin
            vpos = 11'd0;
        end else if (h_lead) begin
            vpos = v_inc;
        end else begin
            vpos = v_cnt;
        end

        // A line ending on the same sample as the frame counts toward the lock decision.
        meas_h = h_lead ? h_inc : h_total_meas;

        // Fires once, on the sample where h_cnt climbs into saturation.
        wd_hit = !h_lead && (h_cnt == H_MAX - 12'd1);

        in_window = (hpos >= H_LO) && (hpos <= H_HI) && (vpos >= V_LO) && (vpos <= V_HI);
    end

    // Timing tracker, lock FSM and registered pixel outputs; all progress is gated by pix_ce.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= ST_SEARCH;
            h_prev       <= 1'b0;
            v_prev       <= 1'b0;
            h_cnt        <= 12'd0;
            v_cnt        <= 11'd0;
            pix_valid    <= 1'b0;
            pix_x        <= 10'd0;
            pix_y        <= 10'd0;
            pix_data     <= 16'd0;
            frame_start  <= 1'b0;
            locked       <= 1'b0;
            err          <= 1'b0;
            h_total_meas <= 12'd0;
            v_total_meas <= 11'd0;
        end else begin
            // One-cycle pulses drop on every clock, sampled or not.
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            err         <= 1'b0;

            if (pix_ce) begin
                h_prev <= h_sync;
                v_prev <= v_sync;
                h_cnt  <= hpos;
                v_cnt  <= vpos;

                // Pixels are only reported while the sampled timing is trusted.
                if (state == ST_LOCKED && in_window) begin
                    pix_valid   <= 1'b1;
                    pix_x       <= 10'(hpos - H_LO);
                    pix_y       <= 10'(vpos - V_LO);
                    pix_data    <= rgb;
                    frame_start <= (hpos == H_LO) && (vpos == V_LO);
                end

                if (wd_hit) begin
                    // Sync has vanished; only complain if we were tracking something.
                    if (state != ST_SEARCH) begin
                        err <= 1'b1;
                    end
                    locked <= 1'b0;
                    state  <= ST_SEARCH;
                end else begin
                    if (state != ST_SEARCH && h_lead) begin
                        h_total_meas <= h_inc;
                    end
                    if (state != ST_SEARCH && v_lead) begin
                        v_total_meas <= v_inc;
                    end

                    case (state)
                        ST_SEARCH: begin
                            if (v_lead) begin
                                state <= ST_MEASURE;
                            end
                        end
                        ST_MEASURE: begin
                            if (v_lead) begin
                                if (meas_h == H_TOT && v_inc == V_TOT) begin
                                    state  <= ST_LOCKED;
                                    locked <= 1'b1;
                                end else begin
                                    // Stay and re-measure the frame that starts here.
                                    err <= 1'b1;
                                end
                            end
                        end
                        ST_LOCKED: begin
                            if ((h_lead && h_inc != H_TOT) || (v_lead && v_inc != V_TOT)) begin
                                err    <= 1'b1;
                                locked <= 1'b0;
                                state  <= ST_SEARCH;
                            end
                        end
                        default: begin
                            state <= ST_SEARCH;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_rx_decoder.sv
module tb_vga_rx_decoder;

    // Scaled-down timing so whole frames fit in a short run; the watchdog limit stays at 4095.
    localparam int HT   = 40;
    localparam int HA   = 10;
    localparam int HV   = 24;
    localparam int VT   = 12;
    localparam int VA   = 3;
    localparam int VV   = 8;
    localparam int HS_W = 4;
    localparam int VS_W = 2;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        pix_ce  = 1'b0;
    logic        h_sync  = 1'b0;
    logic        v_sync  = 1'b0;
    logic [15:0] rgb     = 16'd0;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [15:0] pix_data;
    logic        frame_start;
    logic        locked;
    logic        err;
    logic [11:0] h_total_meas;
    logic [10:0] v_total_meas;

    vga_rx_decoder #(
        .SYNC_POL(1), .H_TOTAL(HT), .H_ACT_START(HA), .H_VALID(HV),
        .V_TOTAL(VT), .V_ACT_START(VA), .V_VALID(VV)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .pix_ce(pix_ce),
        .h_sync(h_sync), .v_sync(v_sync), .rgb(rgb),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .frame_start(frame_start), .locked(locked), .err(err),
        .h_total_meas(h_total_meas), .v_total_meas(v_total_meas)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (integers, spec-level rules).
    int m_hc, m_vc;
    bit m_hp, m_vp, m_meas, m_lock;
    logic        e_valid, e_fs, e_locked, e_err;
    logic [9:0]  e_x, e_y;
    logic [15:0] e_data;
    logic [11:0] e_ht;
    logic [10:0] e_vt;

    // Observation counters over a stretch of stimulus.
    int pv_cnt, err_cnt, fs_cnt;
    int first_x, first_y, last_x, last_y;
    bit first_fs;
    bit gap_rand = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_hc = 0; m_vc = 0; m_hp = 0; m_vp = 0; m_meas = 0; m_lock = 0;
        e_valid = 0; e_fs = 0; e_locked = 0; e_err = 0;
        e_x = 0; e_y = 0; e_data = 0; e_ht = 0; e_vt = 0;
    endtask

    task automatic clear_counts();
        pv_cnt = 0; err_cnt = 0; fs_cnt = 0;
        first_x = -1; first_y = -1; last_x = -1; last_y = -1; first_fs = 0;
    endtask

    // Predicts the outputs after the next clock edge for the inputs about to be sampled.
    task automatic model_step(input logic ce, input logic hs, input logic vs, input logic [15:0] d);
        int len, vlen, hp, vp;
        bit hl, vl, wd, was_lock;
        e_valid = 0; e_fs = 0; e_err = 0;
        if (ce) begin
            hl   = hs && !m_hp;
            vl   = vs && !m_vp;
            len  = (m_hc + 1 > 4095) ? 4095 : m_hc + 1;
            vlen = (m_vc + 1 > 2047) ? 2047 : m_vc + 1;
            hp   = hl ? 0 : len;
            vp   = vl ? 0 : (hl ? vlen : m_vc);
            wd   = !hl && (len == 4095) && (m_hc != 4095);
            was_lock = m_lock;
            if (wd) begin
                if (m_lock || m_meas) e_err = 1;
                m_lock = 0; m_meas = 0;
            end else begin
                if ((m_lock || m_meas) && hl) e_ht = 12'(len);
                if ((m_lock || m_meas) && vl) e_vt = 11'(vlen);
                if (m_lock) begin
                    if ((hl && len != HT) || (vl && vlen != VT)) begin
                        e_err = 1; m_lock = 0;
                    end
                end else if (m_meas) begin
                    if (vl) begin
                        if (e_ht == HT && vlen == VT) begin
                            m_lock = 1; m_meas = 0;
                        end else begin
                            e_err = 1;
                        end
                    end
                end else if (vl) begin
                    m_meas = 1;
                end
            end
            if (was_lock && hp >= HA && hp < HA + HV && vp >= VA && vp < VA + VV) begin
                e_valid = 1;
                e_x     = 10'(hp - HA);
                e_y     = 10'(vp - VA);
                e_data  = d;
                e_fs    = (hp == HA) && (vp == VA);
            end
            e_locked = m_lock;
            m_hc = hp; m_vc = vp; m_hp = hs; m_vp = vs;
        end
    endtask

    task automatic check_outputs();
        chk("pix_valid", pix_valid, e_valid);
        chk("pix_x", pix_x, e_x);
        chk("pix_y", pix_y, e_y);
        chk("pix_data", pix_data, e_data);
        chk("frame_start", frame_start, e_fs);
        chk("locked", locked, e_locked);
        chk("err", err, e_err);
        chk("h_total_meas", h_total_meas, e_ht);
        chk("v_total_meas", v_total_meas, e_vt);
    endtask

    // One sys_clk cycle: drive, predict, then compare just after the edge.
    task automatic tick(input logic ce, input logic hs, input logic vs, input logic [15:0] d);
        pix_ce = ce; h_sync = hs; v_sync = vs; rgb = d;
        model_step(ce, hs, vs, d);
        @(posedge sys_clk);
        #1;
        check_outputs();
        if (pix_valid) begin
            pv_cnt++;
            if (pv_cnt == 1) begin
                first_x = pix_x; first_y = pix_y; first_fs = frame_start;
            end
            last_x = pix_x; last_y = pix_y;
        end
        if (frame_start) fs_cnt++;
        if (err) err_cnt++;
    endtask

    task automatic sample(input logic hs, input logic vs, input logic [15:0] d);
        int gap;
        gap = gap_rand ? $urandom_range(0, 2) : 1;
        repeat (gap) tick(1'b0, hs, vs, 16'($urandom));
        tick(1'b1, hs, vs, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) sample(1'b0, 1'b0, 16'($urandom));
    endtask

    // Lines l0..l1-1 of a frame; bad_line gets one extra sample; rnd selects random pixel data.
    task automatic send_lines(input int l0, input int l1, input int bad_line, input bit rnd);
        int len;
        logic [9:0] xv, yv;
        logic [15:0] d;
        for (int l = l0; l < l1; l++) begin
            len = (l == bad_line) ? HT + 1 : HT;
            for (int s = 0; s < len; s++) begin
                xv = 10'(s - HA);
                yv = 10'(l - VA);
                if (rnd) d = 16'($urandom);
                else if (s >= HA && s < HA + HV && l >= VA && l < VA + VV) d = {xv[4:0], yv[5:0], xv[4:0]};
                else d = 16'd0;
                sample(s < HS_W, l < VS_W, d);
            end
        end
    endtask

    initial begin
        model_reset();
        clear_counts();

        // Reset state.
        repeat (3) @(posedge sys_clk);
        #1;
        check_outputs();
        chk("rst_locked", locked, 0);
        chk("rst_pix_valid", pix_valid, 0);
        sys_rst = 1'b0;

        // Nominal lock: locks at the second v leading edge, frame B carries pixels.
        idle(5);
        send_lines(0, VT, -1, 0);
        chk("A_locked", locked, 0);
        chk("A_err", err_cnt, 0);
        clear_counts();
        send_lines(0, VT, -1, 0);
        chk("B_locked", locked, 1);
        chk("B_err", err_cnt, 0);
        chk("B_h_meas", h_total_meas, HT);
        chk("B_v_meas", v_total_meas, VT);
        chk("B_pixels", pv_cnt, HV * VV);
        chk("B_frame_starts", fs_cnt, 1);
        chk("B_first_fs", first_fs, 1);
        chk("B_first_x", first_x, 0);
        chk("B_first_y", first_y, 0);
        chk("B_last_x", last_x, HV - 1);
        chk("B_last_y", last_y, VV - 1);

        // Random data and irregular pix_ce spacing while locked.
        gap_rand = 1'b1;
        clear_counts();
        send_lines(0, VT, -1, 1);
        chk("C_pixels", pv_cnt, HV * VV);
        chk("C_err", err_cnt, 0);
        gap_rand = 1'b0;

        // Bad line in a locked frame, then relock after the next full nominal frame.
        clear_counts();
        send_lines(0, VT, 5, 0);
        chk("D_err", err_cnt, 1);
        chk("D_locked", locked, 0);
        chk("D_pixels", pv_cnt, 3 * HV);
        clear_counts();
        send_lines(0, VT, -1, 0);
        chk("E_locked", locked, 0);
        send_lines(0, VT, -1, 0);
        chk("F_locked", locked, 1);
        chk("EF_err", err_cnt, 0);

        // Sync loss: watchdog fires once.
        clear_counts();
        idle(5000);
        chk("loss_err", err_cnt, 1);
        chk("loss_locked", locked, 0);
        chk("loss_pixels", pv_cnt, 0);

        // Short frame while measuring, then lock on the following nominal frame.
        clear_counts();
        send_lines(0, VT - 1, -1, 0);
        send_lines(0, VT, -1, 0);
        chk("H_err", err_cnt, 1);
        chk("H_locked", locked, 0);
        chk("H_v_meas", v_total_meas, VT - 1);
        clear_counts();
        send_lines(0, VT, -1, 1);
        chk("I_locked", locked, 1);
        chk("I_v_meas", v_total_meas, VT);
        chk("I_err", err_cnt, 0);

        // pix_ce held low with toggling syncs mid-frame, then resume; then async reset.
        clear_counts();
        send_lines(0, 6, -1, 0);
        for (int i = 0; i < 1000; i++) tick(1'b0, 1'($urandom), 1'($urandom), 16'($urandom));
        send_lines(6, 9, -1, 0);
        chk("J_pixels", pv_cnt, 6 * HV);
        chk("J_err", err_cnt, 0);
        chk("pre_rst_locked", locked, 1);
        pix_ce = 1'b0;
        #3;
        sys_rst = 1'b1;
        #1;
        chk("arst_pix_valid", pix_valid, 0);
        chk("arst_pix_x", pix_x, 0);
        chk("arst_pix_y", pix_y, 0);
        chk("arst_pix_data", pix_data, 0);
        chk("arst_frame_start", frame_start, 0);
        chk("arst_locked", locked, 0);
        chk("arst_err", err, 0);
        chk("arst_h_meas", h_total_meas, 0);
        chk("arst_v_meas", v_total_meas, 0);
        model_reset();
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;

        // Relock after reset.
        clear_counts();
        idle(5);
        send_lines(0, VT, -1, 0);
        chk("K_locked", locked, 0);
        chk("K_pixels", pv_cnt, 0);
        clear_counts();
        send_lines(0, VT, -1, 0);
        chk("L_locked", locked, 1);
        chk("L_pixels", pv_cnt, HV * VV);
        chk("L_err", err_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_rx_decoder.md
Name: vga_rx_decoder

Overview:
- Receive side of the VGA video interface: consumes the h_sync/v_sync/RGB565 stream a VGA generator drives and recovers pixel coordinates and pixel data.
- Measures line and frame timing and locks once a full frame matches nominal 640x480@60 timing.
- Emits a qualified pixel stream for capture, checking or loop-back testing of the video path.
- Sits on sys_clk; samples are qualified by pix_ce, the pixel-rate strobe (25 MHz from 50 MHz).

Parameters:
- SYNC_POL, 1, sync active level (1 = sync pulse is high)
- H_TOTAL, 800, expected samples per line
- H_ACT_START, 144, line position of first active pixel (sync + back porch + left border)
- H_VALID, 640, active pixels per line
- V_TOTAL, 525, expected lines per frame
- V_ACT_START, 35, line number of first active line
- V_VALID, 480, active lines per frame

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  asynchronous, active-high reset
- pix_ce  in  1  sample strobe; inputs are sampled only when high
- h_sync  in  1  horizontal sync
- v_sync  in  1  vertical sync
- rgb  in  16  pixel data, RGB565
- pix_valid  out  1  pixel output qualifier, one cycle per active pixel
- pix_x  out  10  active column 0..639
- pix_y  out  10  active row 0..479
- pix_data  out  16  captured rgb
- frame_start  out  1  one-cycle pulse with pixel (0,0)
- locked  out  1  timing locked
- err  out  1  one-cycle pulse on timing violation
- h_total_meas  out  12  last measured line length
- v_total_meas  out  11  last measured frame length (lines)

Behaviour:
- One clock domain; reset is asynchronous and active-high.
- Reset value of every output is 0; state = SEARCH.
- Reset asserted mid-frame clears all outputs immediately; no partial frame is reported after release.
- Nothing changes on cycles with pix_ce=0 except deassertion of one-cycle pulses.
- Edge detection: registered previous sync samples; a leading edge is sync==SYNC_POL now and !=SYNC_POL at the previous pix_ce sample.
- Horizontal position hpos of a sample:
  - 0 on an h leading edge, else h_cnt+1.
  - h_cnt is 12 bits and saturates at 4095.
  - Line length at an h edge = previous h_cnt+1.
- Vertical line counter v_cnt (11 bits):
  - Cleared on a v leading edge.
  - Otherwise incremented on an h leading edge.
  - Simultaneous h and v edges: v_cnt=0, hpos=0.
- FSM:
  - SEARCH: wait for a v leading edge, then go to MEASURE and clear the line counter.
  - MEASURE:
    - Update h_total_meas at every h edge.
    - At the next v edge, latch v_total_meas = v_cnt+1.
    - If h_total_meas==H_TOTAL and v_total_meas==V_TOTAL, go to LOCKED and set locked=1 (same cycle).
    - Otherwise pulse err and stay in MEASURE, re-measuring from that edge.
  - LOCKED:
    - Every h edge checks line length==H_TOTAL.
    - Every v edge checks lines==V_TOTAL.
    - On mismatch: err pulse, locked=0, go to SEARCH.
  - Watchdog (any state): h_cnt reaching 4095 gives err pulse (only if locked or MEASURE), locked=0, SEARCH.
- Pixel output (LOCKED only), registered with 1 sys_clk latency after the qualifying pix_ce sample:
  - Qualifier: hpos in [H_ACT_START, H_ACT_START+H_VALID-1] and v_cnt in [V_ACT_START, V_ACT_START+V_VALID-1].
  - pix_valid=1, pix_x=hpos-H_ACT_START, pix_y=v_cnt-V_ACT_START, pix_data=rgb.
  - frame_start=1 with pixel (0,0) only.
- pix_x, pix_y and pix_data hold their last value when pix_valid=0.
- The first frame delivering pixels is the one starting at the v edge that sets locked.

Test Plan:
- Nominal lock: reset, then ideal 800x525 timing (sync high, h_sync 96 samples, v_sync 2 lines), pix_ce every 2nd cycle -> locked rises at the 2nd v leading edge; h_total_meas=800, v_total_meas=525, err never pulses.
- Pixel stream: rgb={x[4:0],y[5:0],x[4:0]} in the active window -> exactly 307200 pix_valid pulses per frame; first is x=0,y=0 with frame_start; last is x=639,y=479; every pix_data matches the pattern; valid pulses occur 1 cycle after the sample.
- Bad line: one line of 801 samples in a locked frame -> err pulse at that h edge, locked=0; relock at the v edge ending the next fully nominal frame.
- Bad frame in MEASURE: 524-line frame -> err at the v edge, locked stays 0; the following 525-line frame locks.
- Sync loss: h_sync held inactive for 5000 samples while locked -> err once when h_cnt hits 4095, locked=0, no pix_valid.
- Async reset mid-frame and pix_ce gating: sys_rst asserted mid-frame -> all outputs 0 without a clock edge; pix_ce held low for 1000 cycles with toggling syncs -> no state/output change; relock after release per the first scenario.
